// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// datapath select codes and the per-state control word decode.
package mcu_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [STATE_W-1:0] ST_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] ST_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] ST_MEM_ADDR = 4'd2;
  localparam logic [STATE_W-1:0] ST_MEM_RD   = 4'd3;
  localparam logic [STATE_W-1:0] ST_MEM_WB   = 4'd4;
  localparam logic [STATE_W-1:0] ST_MEM_WR   = 4'd5;
  localparam logic [STATE_W-1:0] ST_EXEC     = 4'd6;
  localparam logic [STATE_W-1:0] ST_R_WB     = 4'd7;
  localparam logic [STATE_W-1:0] ST_BRANCH   = 4'd8;
  localparam logic [STATE_W-1:0] ST_JUMP     = 4'd9;
  localparam logic [STATE_W-1:0] ST_ADDI_EX  = 4'd10;
  localparam logic [STATE_W-1:0] ST_ADDI_WB  = 4'd11;
  localparam logic [STATE_W-1:0] ST_FAULT    = 4'd12;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       fault;
  } ctrl_t;

  // Moore decode: control word depends on the state alone.
  function automatic ctrl_t decode_state(input logic [STATE_W-1:0] st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
        c.reg_dst    = REGDST_RT;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RD;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      ST_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = M2R_ALUOUT;
      end
      ST_FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating count of consecutive memory wait cycles; cleared whenever the
// controller changes state.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic at_limit_c
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit_c = (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM (Moore). Define MCTRL_MEM_WAIT_EN to
// stall FETCH/MEM_RD/MEM_WR on mem_ready with a WAIT_LIMIT timeout fault.
module multi_cycle_ctrl
  import mcu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state_o,
  output logic       fault,
  output logic [1:0] fault_cause
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         fault_cause_q, fault_cause_d;
  logic               mem_ok_c;
  logic               timeout_c;
  logic               unused_ok;
  ctrl_t              ctrl_c;

`ifdef MCTRL_MEM_WAIT_EN
  logic wait_state_c;
  logic waiting_c;
  logic at_limit_c;

  assign wait_state_c = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                        (state_q == ST_MEM_WR);
  assign waiting_c    = wait_state_c && !mem_ready;
  assign mem_ok_c     = mem_ready;
  assign timeout_c    = waiting_c && at_limit_c;
  assign unused_ok    = alu_zero;

  mc_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (state_d != state_q),
    .inc_i      (waiting_c),
    .at_limit_c (at_limit_c)
  );
`else
  // Memory is always ready in a single cycle in this build.
  assign mem_ok_c  = 1'b1;
  assign timeout_c = 1'b0;
  assign unused_ok = ^{alu_zero, mem_ready, WAIT_LIMIT};
`endif

  // Next-state and fault-cause capture.
  always_comb begin
    state_d       = state_q;
    fault_cause_d = fault_cause_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ok_c) begin
          state_d = ST_DECODE;
        end else if (timeout_c) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
          default: begin
            state_d       = ST_FAULT;
            fault_cause_d = FC_ILLEGAL;
          end
        endcase
      end
      ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ok_c) begin
          state_d = ST_MEM_WB;
        end else if (timeout_c) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_TIMEOUT;
        end
      end
      ST_MEM_WR: begin
        if (mem_ok_c) begin
          state_d = ST_FETCH;
        end else if (timeout_c) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_TIMEOUT;
        end
      end
      ST_EXEC:    state_d = ST_R_WB;
      ST_ADDI_EX: state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: state_d = ST_FETCH;
      ST_FAULT:   state_d = ST_FAULT;
      default: begin
        state_d       = ST_FAULT;
        fault_cause_d = FC_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      fault_cause_q <= FC_NONE;
    end else begin
      state_q       <= state_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  // Control word from state; forced quiet while reset is held.
  always_comb begin
    ctrl_c = decode_state(state_q);
`ifdef MCTRL_MEM_WAIT_EN
    if ((state_q == ST_FETCH) && !mem_ready) begin
      ctrl_c.pc_write = 1'b0;
      ctrl_c.ir_write = 1'b0;
    end
`endif
    if (!rst_n) begin
      ctrl_c = '0;
    end
  end

  assign pc_write      = ctrl_c.pc_write;
  assign pc_write_cond = ctrl_c.pc_write_cond;
  assign i_or_d        = ctrl_c.i_or_d;
  assign mem_read      = ctrl_c.mem_read;
  assign mem_write     = ctrl_c.mem_write;
  assign ir_write      = ctrl_c.ir_write;
  assign reg_dst       = ctrl_c.reg_dst;
  assign mem_to_reg    = ctrl_c.mem_to_reg;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign alu_op        = ctrl_c.alu_op;
  assign pc_source     = ctrl_c.pc_source;
  assign fault         = ctrl_c.fault;
  assign fault_cause   = fault_cause_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed and random instruction
// streams against a per-instruction state-path model.
module tb_multi_cycle_ctrl;

  localparam int unsigned TB_WAIT_LIMIT = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;
  logic       fault;
  logic [1:0] fault_cause;
  logic [20:0] obs_out;

  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl #(.WAIT_LIMIT(TB_WAIT_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state_o(state_o),
    .fault(fault), .fault_cause(fault_cause)
  );

  assign obs_out = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, fault, fault_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Sequence of states visited from one FETCH up to (not including) the next.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      6'h23:               return 5;
      6'h2B, 6'h00, 6'h08: return 4;
      default:             return 3;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input logic [5:0] op, input int i);
    logic [3:0] p [5];
    p[0] = 4'd0; p[1] = 4'd1; p[2] = 4'd12; p[3] = 4'd12; p[4] = 4'd12;
    case (op)
      6'h23: begin p[2] = 4'd2; p[3] = 4'd3; p[4] = 4'd4; end
      6'h2B: begin p[2] = 4'd2; p[3] = 4'd5; end
      6'h00: begin p[2] = 4'd6; p[3] = 4'd7; end
      6'h08: begin p[2] = 4'd10; p[3] = 4'd11; end
      6'h04: p[2] = 4'd8;
      6'h02: p[2] = 4'd9;
      default: ;
    endcase
    return p[i];
  endfunction

  // Expected control outputs for a state, written from the instruction table.
  function automatic logic [20:0] exp_out(input logic [3:0] st, input logic rdy,
                                          input logic [1:0] cause);
    logic pcw, pcwc, iod, mr, mw, irw, rw, asa, flt, stall;
    logic [1:0] rd, m2r, asb, aop, pcs, fc;
    {pcw, pcwc, iod, mr, mw, irw, rw, asa, flt} = '0;
    {rd, m2r, asb, aop, pcs, fc} = '0;
`ifdef MCTRL_MEM_WAIT_EN
    stall = !rdy;
`else
    stall = 1'b0 & rdy;
`endif
    case (st)
      4'd0:  begin mr = 1; irw = !stall; pcw = !stall; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 2'b01; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 2'b01; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      4'd12: begin flt = 1; fc = cause; end
      default: ;
    endcase
    return {pcw, pcwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, flt, fc};
  endfunction

  function automatic logic pick_ready();
`ifdef MCTRL_MEM_WAIT_EN
    return 1'b1;
`else
    return 1'($urandom);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive mem_ready, check, advance one cycle.
  task automatic step(input logic [3:0] st, input logic rdy, input logic [1:0] cause,
                      input string tag);
    mem_ready = rdy;
    #1;
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_outs"}, 32'(obs_out), 32'(exp_out(st, rdy, cause)));
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input string tag);
    int n;
    n = path_len(op);
    opcode   = op;
    alu_zero = z;
    for (int i = 0; i < n; i++) begin
      step(path_state(op, i), pick_ready(), 2'b01, tag);
    end
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_state"}, 32'(state_o), 32'd0);
    chk({tag, "_rst_outs"}, 32'(obs_out), 32'd0);
    @(negedge clk);
    chk({tag, "_rst_hold_outs"}, 32'(obs_out), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] legal [6];
    legal[0] = 6'h00; legal[1] = 6'h02; legal[2] = 6'h04;
    legal[3] = 6'h08; legal[4] = 6'h23; legal[5] = 6'h2B;

    rst_n = 1'b0; opcode = 6'h00; alu_zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outs", 32'(obs_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'h23, 1'b0, "lw");
    run_instr(6'h2B, 1'b0, "sw");
    run_instr(6'h00, 1'b1, "rtype");
    run_instr(6'h08, 1'b0, "addi");
    run_instr(6'h04, 1'b1, "beq_taken");
    run_instr(6'h04, 1'b0, "beq_not");
    run_instr(6'h02, 1'b0, "jump");

    for (int k = 0; k < 40; k++) begin
      run_instr(legal[$urandom_range(0, 5)], 1'($urandom), "rand");
    end

`ifdef MCTRL_MEM_WAIT_EN
    // FETCH stalls three cycles with PC/IR loads suppressed.
    opcode = 6'h02;
    for (int k = 0; k < 3; k++) step(4'd0, 1'b0, 2'b00, "fetch_wait");
    step(4'd0, 1'b1, 2'b00, "fetch_go");
    step(4'd1, 1'b1, 2'b00, "fetch_wait_dec");
    step(4'd9, 1'b1, 2'b00, "fetch_wait_j");

    // Ready arriving on the limit cycle wins over the timeout.
    opcode = 6'h23;
    step(4'd0, 1'b1, 2'b00, "lim_win");
    step(4'd1, 1'b1, 2'b00, "lim_win");
    step(4'd2, 1'b1, 2'b00, "lim_win");
    for (int k = 0; k < int'(TB_WAIT_LIMIT); k++) step(4'd3, 1'b0, 2'b00, "lim_win_wait");
    step(4'd3, 1'b1, 2'b00, "lim_win_last");
    step(4'd4, 1'b1, 2'b00, "lim_win_wb");
`endif

    // Reset dropped while in MEM_RD (mid-wait when waits are enabled).
    opcode = 6'h23;
    step(4'd0, 1'b1, 2'b00, "rst_mid");
    step(4'd1, 1'b1, 2'b00, "rst_mid");
    step(4'd2, 1'b1, 2'b00, "rst_mid");
`ifdef MCTRL_MEM_WAIT_EN
    step(4'd3, 1'b0, 2'b00, "rst_mid_wait");
    mem_ready = 1'b0;
`else
    mem_ready = 1'b1;
`endif
    #1 chk("rst_mid_pre_state", 32'(state_o), 32'd3);
    pulse_reset("rst_mid");
    run_instr(6'h00, 1'b0, "after_rst");

`ifdef MCTRL_MEM_WAIT_EN
    // mem_ready stuck low in MEM_WR times out after WAIT_LIMIT tolerated cycles.
    opcode = 6'h2B;
    step(4'd0, 1'b1, 2'b00, "timeout");
    step(4'd1, 1'b1, 2'b00, "timeout");
    step(4'd2, 1'b1, 2'b00, "timeout");
    for (int k = 0; k <= int'(TB_WAIT_LIMIT); k++) step(4'd5, 1'b0, 2'b00, "timeout_wait");
    for (int k = 0; k < 3; k++) step(4'd12, 1'($urandom), 2'b10, "timeout_fault");
    pulse_reset("timeout");
    run_instr(6'h08, 1'b0, "after_timeout");
`endif

    // Illegal opcode: FAULT after DECODE, held until reset.
    opcode = 6'h3F;
    step(4'd0, 1'b1, 2'b00, "illegal");
    step(4'd1, 1'b1, 2'b00, "illegal");
    for (int k = 0; k < 10; k++) begin
      opcode = 6'($urandom);
      step(4'd12, 1'($urandom), 2'b01, "illegal_fault");
    end
    pulse_reset("illegal");
    run_instr(6'h23, 1'b0, "after_illegal");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
